reg_write_arbiter: RTL

- Shares the single write port of the 64x32 register bank between N_REQ write-back sources: ALU result, memory/IO load, and link/stack update.
- Round-robin arbitration with a registered req/gnt handshake.
- Drives the bank's Write_Register / Write_Data / Reg_Write from registers.
- Enforces the register-0-is-zero rule.
- Sits between the control unit/datapath sources and the register bank; the bank samples its outputs on the same clock edge.

---
 rtl/reg_write_arbiter_pkg.sv | 10 +
 rtl/reg_write_arbiter_rr_select.sv | 28 ++
 rtl/reg_write_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared widths and requester indices for the register-bank write port.
package reg_write_arbiter_pkg;
   localparam int REG_ADDR_W = 6;
   localparam int REG_DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 6'd0;

   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;
   localparam int REQ_LINK = 2;
endpackage

// File: rtl/reg_write_arbiter_rr_select.sv
// Combinational round-robin pick: first set bit of elig scanning upward from
// rr_ptr and wrapping modulo N_REQ.
module rr_select #(
   parameter int N_REQ = 3,
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] elig_i,
   input  logic [IDX_W-1:0] rr_ptr_i,
   output logic [IDX_W-1:0] winner_o,
   output logic             valid_o
);
   logic [IDX_W:0] idx;

   // Scan from the far end so the candidate closest to rr_ptr is assigned last.
   always_comb begin
      winner_o = '0;
      valid_o  = 1'b0;
      idx      = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, rr_ptr_i} + (IDX_W + 1)'(k);
         if (idx >= (IDX_W + 1)'(N_REQ)) idx = idx - (IDX_W + 1)'(N_REQ);
         if (elig_i[idx[IDX_W-1:0]]) begin
            winner_o = idx[IDX_W-1:0];
            valid_o  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port; all bank-facing
// outputs are registered and writes to register 0 are suppressed.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic                      stall,
   output logic [N_REQ-1:0]          gnt,
   output logic [ADDR_W-1:0]         Write_Register,
   output logic [DATA_W-1:0]         Write_Data,
   output logic                      Reg_Write,
   output logic                      drop_r0
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [ADDR_W-1:0] wreg_q, wreg_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              drop_q, drop_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic [N_REQ-1:0]  elig;
   logic [IDX_W-1:0]  win;
   logic              win_vld;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   // The requester granted last cycle is still withdrawing; keep it out.
   assign elig = req & ~gnt_q;

   rr_select #(.N_REQ(N_REQ)) u_sel (
      .elig_i   (elig),
      .rr_ptr_i (rr_ptr_q),
      .winner_o (win),
      .valid_o  (win_vld)
   );

   assign win_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
   assign win_data = req_data[int'(win)*DATA_W +: DATA_W];

   always_comb begin
      gnt_d    = '0;
      we_d     = 1'b0;
      drop_d   = 1'b0;
      wreg_d   = wreg_q;
      wdata_d  = wdata_q;
      rr_ptr_d = rr_ptr_q;
      if (!stall && win_vld) begin
         gnt_d[win] = 1'b1;
         wreg_d     = win_addr;
         wdata_d    = win_data;
         we_d       = (win_addr != ADDR_W'(REG_ZERO));
         drop_d     = (win_addr == ADDR_W'(REG_ZERO));
         rr_ptr_d   = (int'(win) == N_REQ - 1) ? '0 : win + IDX_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gnt_q    <= '0;
         wreg_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         drop_q   <= 1'b0;
         rr_ptr_q <= '0;
      end else begin
         gnt_q    <= gnt_d;
         wreg_q   <= wreg_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         drop_q   <= drop_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign gnt            = gnt_q;
   assign Write_Register = wreg_q;
   assign Write_Data     = wdata_q;
   assign Reg_Write      = we_q;
   assign drop_r0        = drop_q;
endmodule
